muldiv_seq: RTL and testbench



---
 rtl/muldiv_seq.sv | 136 +++++++++++++
 tb/tb_muldiv_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with the HI/LO pair, driving an external ALU.
// Shift-add multiply and restoring divide share one accumulator pair; signs are fixed in a single FIX cycle.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [2:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
  state_t state, state_nx;

  logic [1:0]         op_q;
  logic               sp, sr, dz;
  logic [CW-1:0]      cnt;
  // acc_hi/acc_lo hold {ph, pl} for multiply and {r, q} for divide.
  logic [WIDTH-1:0]   acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0]   abs_a, abs_b, rs, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod_neg;
  logic               is_div, carry_m, take;

  assign is_div   = op_q[1];
  assign abs_a    = (op[0] && a[WIDTH-1]) ? -a : a;
  assign abs_b    = (op[0] && b[WIDTH-1]) ? -b : b;
  assign rs       = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign carry_m  = (alu_result < acc_hi);
  // acc_hi[MSB] is the bit shifted out of the 33-bit partial remainder.
  assign take     = acc_hi[WIDTH-1] | (rs >= opnd);
  assign prod_neg = -{acc_hi, acc_lo};

  always_comb begin
    hi_fix = acc_hi;
    lo_fix = acc_lo;
    if (!is_div) begin
      if (sp) {hi_fix, lo_fix} = prod_neg;
    end else begin
      // Divide by zero leaves q all-ones; only the remainder sign is restored to give back a.
      if (sp && !dz) lo_fix = -acc_lo;
      if (sr)        hi_fix = -acc_hi;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    alu_ctl  = 3'b000;
    alu_a    = '0;
    alu_b    = '0;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        alu_ctl = is_div ? 3'b110 : 3'b010;
        alu_a   = is_div ? rs : acc_hi;
        alu_b   = opnd;
        if (cnt == LAST) state_nx = S_FIX;
      end
      S_FIX:   state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= '0;
      sp     <= 1'b0;
      sr     <= 1'b0;
      dz     <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q   <= op;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_a : abs_b;
            opnd   <= op[1] ? abs_b : abs_a;
            sp     <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            sr     <= op[0] & a[WIDTH-1];
            dz     <= op[1] & (b == '0);
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (is_div) begin
            acc_hi <= take ? alu_result : rs;
            acc_lo <= {acc_lo[WIDTH-2:0], take};
          end else if (acc_lo[0]) begin
            {acc_hi, acc_lo} <= {carry_m, alu_result, acc_lo[WIDTH-1:1]};
          end else begin
            {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
          end
        end
        S_FIX: begin
          acc_hi <= hi_fix;
          acc_lo <= lo_fix;
          hi     <= hi_fix;
          lo     <= lo_fix;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: models the external ALU and checks results against plain 64-bit arithmetic.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [2:0]  alu_ctl;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .alu_ctl(alu_ctl), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Environment ALU: add and subtract are the only functions the sequencer uses.
  always_comb begin
    case (alu_ctl)
      3'b010:  alu_result = alu_a + alu_b;
      3'b110:  alu_result = alu_a - alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference result as {hi, lo}.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: p = {32'h0, x} * {32'h0, y};
      2'b01: p = 64'(sx * sy);
      2'b10: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      default: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Runs one operation launched back-to-back; inj adds ignored starts/MT writes while busy.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input bit inj);
    logic [63:0] e;
    logic [31:0] hi0, lo0;
    int dc, bbad, hbad;
    e = ref_md(o, x, y);
    dc = 0; bbad = 0; hbad = 0;
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; a = x; b = y;
    if (inj) begin mtlo = 1'b1; wdata = 32'hDEAD_BEEF; end
    @(posedge clk); #1;
    start = 1'b0; mtlo = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (done && dc == 0) dc = k;
      if (k < 34 && !busy) bbad++;
      if (k < 34 && (hi !== hi0 || lo !== lo0)) hbad++;
      if (dc != 0) break;
      if (inj && k >= 5 && k <= 33) begin
        start = 1'b1; op = 2'($urandom_range(3)); a = $urandom; b = $urandom;
      end else start = 1'b0;
      if (inj && k == 10) begin mtlo = 1'b1; mthi = 1'b1; wdata = 32'h5A5A_5A5A; end
      else begin mtlo = 1'b0; mthi = 1'b0; end
      @(posedge clk); #1;
    end
    start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
    check({tag, "_done_cycle"}, 64'(dc), 64'd34);
    check({tag, "_busy_low_early"}, 64'(bbad), 64'd0);
    check({tag, "_hilo_changed_early"}, 64'(hbad), 64'd0);
    check({tag, "_hilo"}, {hi, lo}, e);
    @(posedge clk); #1;
    check({tag, "_idle_after"}, {62'h0, busy, done}, 64'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hilo", {hi, lo}, 64'h0);
    check("reset_busy_done", {62'h0, busy, done}, 64'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_alu", {29'h0, alu_ctl, alu_a}, 64'h0);
    check("idle_alu_b", {32'h0, alu_b}, 64'h0);

    do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_op("mult_minx2", 2'b01, 32'h8000_0000, 32'd2, 1'b0);
    do_op("divu_100_7", 2'b10, 32'd100, 32'd7, 1'b0);
    check("divu_100_7_const", {hi, lo}, {32'd2, 32'd14});
    do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op("div_by0", 2'b11, 32'h1234_5678, 32'd0, 1'b0);
    check("div_by0_const", {hi, lo}, 64'h1234_5678_FFFF_FFFF);
    do_op("div_neg_by0", 2'b11, 32'h8765_4321, 32'd0, 1'b0);
    do_op("divu_by0", 2'b10, 32'hCAFE_F00D, 32'd0, 1'b0);
    do_op("div_min_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

    @(negedge clk); mtlo = 1'b1; wdata = 32'h0000_00A5;
    @(posedge clk); #1; mtlo = 1'b0;
    check("mtlo_idle", {hi, lo}, {32'h8000_0001 == 32'h0 ? 32'h0 : 32'h7FFF_FFFE, 32'h0000_00A5});
    @(negedge clk); mtlo = 1'b1; mthi = 1'b1; wdata = 32'h1357_9BDF;
    @(posedge clk); #1; mtlo = 1'b0; mthi = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, 64'h1357_9BDF_1357_9BDF);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (ry == 0) ry = 32'd1;
      do_op("rand", 2'(i % 4), rx, ry, (i % 5) == 0);
    end

    // Reset in the middle of a divide.
    @(negedge clk); start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (11) @(posedge clk);
    #1; reset_n = 1'b0; #1;
    check("midop_reset_busy_done", {62'h0, busy, done}, 64'd0);
    check("midop_reset_hilo", {hi, lo}, 64'h0);
    @(negedge clk) reset_n = 1'b1;
    do_op("multu_6x7", 2'b00, 32'd6, 32'd7, 1'b0);
    check("multu_6x7_const", {hi, lo}, 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
